// File: rtl/fifo_rptr_empty.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_rptr_empty
//   Read-side pointer/empty stage of the async FIFO: synchronizes the gray
//   write pointer into rclk and keeps binary read address, gray read pointer
//   and a registered pessimistic empty flag. Optional ASYNC_FIFO_RLEVEL_EN
//   adds registered occupancy (rlevel) and almost-empty (raempty) outputs.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_rptr_empty #(
  parameter int ADDR_SIZE     = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rpop,
  input  logic [ADDR_SIZE:0]   wptr,
  output logic                 ren,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty
`ifdef ASYNC_FIFO_RLEVEL_EN
  ,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 raempty
`endif
);

  localparam int c_PTR_W = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] r_sync [SYNC_STAGES];
  logic [ADDR_SIZE:0] r_rbin;
  logic [ADDR_SIZE:0] w_rbin_next;
  logic [ADDR_SIZE:0] w_rgray_next;
  logic [ADDR_SIZE:0] w_sync_wptr;

  assign ren          = rpop & ~rempty;
  assign w_rbin_next  = r_rbin + {{ADDR_SIZE{1'b0}}, ren};
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  assign w_sync_wptr  = r_sync[SYNC_STAGES-1];

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_rbin <= '0;
      raddr  <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      r_rbin <= w_rbin_next;
      raddr  <= w_rbin_next[ADDR_SIZE-1:0];
      rptr   <= w_rgray_next;
      // Compare against the post-pop pointer so the last pop blocks the next one.
      rempty <= (w_rgray_next == w_sync_wptr);
    end
  end

`ifdef ASYNC_FIFO_RLEVEL_EN
  localparam logic [ADDR_SIZE:0] c_AEMPTY_THRESH = c_PTR_W'(AEMPTY_THRESH);

  logic [ADDR_SIZE:0] w_wbin_sync;
  logic [ADDR_SIZE:0] w_lvl_next;

  always_comb begin
    w_wbin_sync = '0;
    for (int i = 0; i < c_PTR_W; i++) w_wbin_sync[i] = ^(w_sync_wptr >> i);
  end

  assign w_lvl_next = w_wbin_sync - w_rbin_next;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rlevel  <= w_lvl_next;
      raempty <= (w_lvl_next <= c_AEMPTY_THRESH);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_rptr_empty
//   Randomized self-checking bench for fifo_rptr_empty with a count-based
//   reference model and a few hand-computed directed expectations.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_rptr_empty;

  localparam int ADDR_SIZE     = 3;
  localparam int SYNC_STAGES   = 2;
  localparam int AEMPTY_THRESH = 1;
  localparam int c_MOD         = 16;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rpop;
  logic [3:0] wptr;
  logic       ren;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
`ifdef ASYNC_FIFO_RLEVEL_EN
  logic [3:0] rlevel;
  logic       raempty;
`endif

  fifo_rptr_empty #(
    .ADDR_SIZE    (ADDR_SIZE),
    .SYNC_STAGES  (SYNC_STAGES),
    .AEMPTY_THRESH(AEMPTY_THRESH)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rpop   (rpop),
    .wptr   (wptr),
    .ren    (ren),
    .raddr  (raddr),
    .rptr   (rptr),
    .rempty (rempty)
`ifdef ASYNC_FIFO_RLEVEL_EN
    ,
    .rlevel (rlevel),
    .raempty(raempty)
`endif
  );

  always #5 rclk = ~rclk;

  int errors = 0;
  int checks = 0;

  // Model state: true write count, read count, and write counts as seen through the sync delay.
  int wcnt = 0;
  int rd   = 0;
  int hist [SYNC_STAGES];
  bit exp_empty = 1'b1;
  int exp_level = 0;

  function automatic logic [3:0] gray(input int b);
    return 4'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rclk cycle: drive inputs, check ren, advance model at the edge, compare outputs.
  task automatic step(input bit rst_v, input bit pop_v);
    bit ren_exp;
    rrst_n = rst_v;
    rpop   = pop_v;
    wptr   = gray(wcnt);
    #1;
    ren_exp = pop_v && !exp_empty;
    chk("ren", 32'(ren), 32'(ren_exp));
    @(posedge rclk);
    if (!rst_v) begin
      rd = 0;
      for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 0;
      exp_empty = 1'b1;
      exp_level = 0;
    end else begin
      rd = (rd + int'(ren_exp)) % c_MOD;
      exp_level = (hist[SYNC_STAGES-1] - rd + c_MOD) % c_MOD;
      exp_empty = (exp_level == 0);
      for (int i = SYNC_STAGES-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wcnt;
    end
    #1;
    chk("raddr",  32'(raddr),  32'(rd % 8));
    chk("rptr",   32'(rptr),   32'(gray(rd)));
    chk("rempty", 32'(rempty), 32'(exp_empty));
`ifdef ASYNC_FIFO_RLEVEL_EN
    chk("rlevel",  32'(rlevel),  32'(exp_level));
    chk("raempty", 32'(raempty), 32'(exp_level <= AEMPTY_THRESH));
`endif
    // Empty must never deassert while nothing is truly stored.
    if (rst_v && rempty === 1'b0)
      chk("pessimistic_empty", 32'(((wcnt - rd + c_MOD) % c_MOD) != 0), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 0;
    rrst_n = 1'b0;
    rpop   = 1'b0;
    wptr   = '0;

    // Reset for 3 edges
    repeat (3) step(1'b0, 1'b0);
    chk("reset_rempty", 32'(rempty), 32'd1);
    chk("reset_rptr",   32'(rptr),   32'd0);
    chk("reset_raddr",  32'(raddr),  32'd0);
`ifdef ASYNC_FIFO_RLEVEL_EN
    chk("reset_rlevel",  32'(rlevel),  32'd0);
    chk("reset_raempty", 32'(raempty), 32'd1);
`endif

    // Pop while empty is ignored
    repeat (4) step(1'b1, 1'b1);
    chk("emptypop_rptr",   32'(rptr),   32'd0);
    chk("emptypop_rempty", 32'(rempty), 32'd1);

    // Single write arrival: rempty falls on the 3rd edge
    wcnt = 1;
    step(1'b1, 1'b0);
    chk("arrive_e1", 32'(rempty), 32'd1);
    step(1'b1, 1'b0);
    chk("arrive_e2", 32'(rempty), 32'd1);
    step(1'b1, 1'b0);
    chk("arrive_e3", 32'(rempty), 32'd0);
    step(1'b1, 1'b1);
    chk("pop1_raddr",  32'(raddr),  32'd1);
    chk("pop1_rptr",   32'(rptr),   32'b0001);
    chk("pop1_rempty", 32'(rempty), 32'd1);

    // Eight more writes, then drain all eight back to back
    wcnt = 9;
    repeat (3) step(1'b1, 1'b0);
`ifdef ASYNC_FIFO_RLEVEL_EN
    chk("drain_level8", 32'(rlevel), 32'd8);
`endif
    chk("drain_notempty", 32'(rempty), 32'd0);
    repeat (8) step(1'b1, 1'b1);
    chk("drain_raddr",  32'(raddr),  32'd1);
    chk("drain_rptr",   32'(rptr),   32'b1101);
    chk("drain_rempty", 32'(rempty), 32'd1);
`ifdef ASYNC_FIFO_RLEVEL_EN
    chk("drain_raempty", 32'(raempty), 32'd1);
`endif

    // Randomized interleaved traffic covering many pointer wraps
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin
        // Mid-operation reset of both domains
        wcnt = 0;
        step(1'b0, 1'b1);
        chk("midrst_rempty", 32'(rempty), 32'd1);
        chk("midrst_rptr",   32'(rptr),   32'd0);
        chk("midrst_raddr",  32'(raddr),  32'd0);
      end else begin
        if (((wcnt - rd + c_MOD) % c_MOD) < 8 && ($urandom % 2) == 0)
          wcnt = (wcnt + 1) % c_MOD;
        step(1'b1, ($urandom % 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
